// File: rtl/pll_reconfig_master.sv
// pll_reconfig_master: Avalon-MM initiator that programs N, M, fractional K and
// one C counter into a PLL reconfiguration block, starts the update and then
// waits for the PLL to drop and regain lock. Reports a done pulse or a sticky
// lock-timeout error.
module pll_reconfig_master #(
    parameter int unsigned FRAC_EN      = 32'd1,
    parameter int unsigned UNLOCK_WAIT  = 32'd256,
    parameter int unsigned LOCK_TIMEOUT = 32'd2000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [17:0] req_n,
    input  logic [17:0] req_m,
    input  logic [31:0] req_k,
    input  logic [22:0] req_c,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // One counter serves both wait phases, so it is sized for the longer one.
    localparam int unsigned CNT_MAX = (UNLOCK_WAIT > LOCK_TIMEOUT) ? UNLOCK_WAIT : LOCK_TIMEOUT;
    localparam int unsigned CNT_W   = (CNT_MAX > 32'd1) ? $clog2(CNT_MAX) : 32'd1;
    localparam logic [CNT_W-1:0] UNLOCK_LAST = CNT_W'(UNLOCK_WAIT - 32'd1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_W_MODE      = 4'd1,
        ST_W_N         = 4'd2,
        ST_W_M         = 4'd3,
        ST_W_K         = 4'd4,
        ST_W_C         = 4'd5,
        ST_W_START     = 4'd6,
        ST_WAIT_UNLOCK = 4'd7,
        ST_WAIT_LOCK   = 4'd8,
        ST_DONE        = 4'd9,
        ST_ERR         = 4'd10
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [17:0]      n_q, m_q;
    logic [31:0]      k_q;
    logic [22:0]      c_q;
    logic             error_q;
    logic             lk_meta_q, lk_sync_q;
    logic             accept_s;
    logic             wr_ok_s;

    assign accept_s = req_valid && (state_q == ST_IDLE);
    assign wr_ok_s  = !mgmt_waitrequest;

    // Two-flop synchronizer for the asynchronous lock indicator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_meta_q <= 1'b0;
            lk_sync_q <= 1'b0;
        end else begin
            lk_meta_q <= pll_locked;
            lk_sync_q <= lk_meta_q;
        end
    end

    // State register and shared wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture on acceptance and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q     <= 18'd0;
            m_q     <= 18'd0;
            k_q     <= 32'd0;
            c_q     <= 23'd0;
            error_q <= 1'b0;
        end else if (accept_s) begin
            n_q     <= req_n;
            m_q     <= req_m;
            k_q     <= req_k;
            c_q     <= req_c;
            error_q <= 1'b0;
        end else if (state_d == ST_ERR) begin
            error_q <= 1'b1;
        end else begin
            error_q <= error_q;
        end
    end

    // Next-state logic: each write state advances only on an unstalled edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:        if (req_valid) state_d = ST_W_MODE; else state_d = ST_IDLE;
            ST_W_MODE:      if (wr_ok_s) state_d = ST_W_N; else state_d = ST_W_MODE;
            ST_W_N:         if (wr_ok_s) state_d = ST_W_M; else state_d = ST_W_N;
            ST_W_M: begin
                if (wr_ok_s) begin
                    if (FRAC_EN != 32'd0) state_d = ST_W_K; else state_d = ST_W_C;
                end else begin
                    state_d = ST_W_M;
                end
            end
            ST_W_K:         if (wr_ok_s) state_d = ST_W_C; else state_d = ST_W_K;
            ST_W_C:         if (wr_ok_s) state_d = ST_W_START; else state_d = ST_W_C;
            ST_W_START:     if (wr_ok_s) state_d = ST_WAIT_UNLOCK; else state_d = ST_W_START;
            // A fast PLL may relock before the drop is ever seen, hence the bounded wait.
            ST_WAIT_UNLOCK: begin
                if (!lk_sync_q || (cnt_q == UNLOCK_LAST)) state_d = ST_WAIT_LOCK;
                else state_d = ST_WAIT_UNLOCK;
            end
            // Lock takes priority over a coincident timeout.
            ST_WAIT_LOCK: begin
                if (lk_sync_q) state_d = ST_DONE;
                else if (cnt_q == LOCK_LAST) state_d = ST_ERR;
                else state_d = ST_WAIT_LOCK;
            end
            ST_DONE:        state_d = ST_IDLE;
            ST_ERR:         state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    // Wait counter: restarts on every state change, saturates while waiting
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = CNT_ZERO;
        end else if (((state_q == ST_WAIT_UNLOCK) || (state_q == ST_WAIT_LOCK)) && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output decode from the state register and captured request
    always_comb begin
        req_ready      = (state_q == ST_IDLE);
        busy           = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
        done           = (state_q == ST_DONE);
        error          = error_q;
        mgmt_write     = 1'b0;
        mgmt_address   = 6'd0;
        mgmt_writedata = 32'd0;
        case (state_q)
            ST_W_MODE: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'd0;
                mgmt_writedata = 32'd0;
            end
            ST_W_N: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'd3;
                mgmt_writedata = {14'd0, n_q};
            end
            ST_W_M: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'd4;
                mgmt_writedata = {14'd0, m_q};
            end
            ST_W_K: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'd7;
                mgmt_writedata = k_q;
            end
            ST_W_C: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'd5;
                mgmt_writedata = {9'd0, c_q};
            end
            ST_W_START: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'd2;
                mgmt_writedata = 32'd1;
            end
            default: begin
                mgmt_write     = 1'b0;
                mgmt_address   = 6'd0;
                mgmt_writedata = 32'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_reconfig_master.sv
// Bench for pll_reconfig_master: one instance with the fractional write enabled
// and one without, a randomizing Avalon responder, a behavioural PLL lock model
// and a write monitor. Expected write lists and latencies are built from the
// register map and the wait-phase rules.
module tb_pll_reconfig_master;

    localparam int UW = 16;
    localparam int LT = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_valid, b_valid;
    logic [17:0] req_n, req_m;
    logic [31:0] req_k;
    logic [22:0] req_c;
    logic        waitreq    = 1'b0;
    logic        pll_locked = 1'b1;

    logic        a_ready, a_write, a_busy, a_done, a_error;
    logic [5:0]  a_addr;
    logic [31:0] a_data;
    logic        b_ready, b_write, b_busy, b_done, b_error;
    logic [5:0]  b_addr;
    logic [31:0] b_data;

    pll_reconfig_master #(.FRAC_EN(1), .UNLOCK_WAIT(UW), .LOCK_TIMEOUT(LT)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
        .req_n(req_n), .req_m(req_m), .req_k(req_k), .req_c(req_c),
        .mgmt_address(a_addr), .mgmt_write(a_write), .mgmt_writedata(a_data),
        .mgmt_waitrequest(waitreq), .pll_locked(pll_locked),
        .busy(a_busy), .done(a_done), .error(a_error));

    pll_reconfig_master #(.FRAC_EN(0), .UNLOCK_WAIT(UW), .LOCK_TIMEOUT(LT)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_n(req_n), .req_m(req_m), .req_k(req_k), .req_c(req_c),
        .mgmt_address(b_addr), .mgmt_write(b_write), .mgmt_writedata(b_data),
        .mgmt_waitrequest(waitreq), .pll_locked(pll_locked),
        .busy(b_busy), .done(b_done), .error(b_error));

    // View of whichever instance is under test
    int          sel = 0;
    logic        m_ready, m_write, m_busy, m_done, m_error;
    logic [5:0]  m_addr;
    logic [31:0] m_data;
    assign m_ready = (sel == 1) ? b_ready : a_ready;
    assign m_write = (sel == 1) ? b_write : a_write;
    assign m_busy  = (sel == 1) ? b_busy  : a_busy;
    assign m_done  = (sel == 1) ? b_done  : a_done;
    assign m_error = (sel == 1) ? b_error : a_error;
    assign m_addr  = (sel == 1) ? b_addr  : a_addr;
    assign m_data  = (sel == 1) ? b_data  : a_data;

    int checks = 0;
    int errors = 0;

    // Monitor state
    int          cyc = 0;
    logic [5:0]  obs_a[$];
    logic [31:0] obs_d[$];
    int          obs_cyc[$];
    int          start_cnt = 0, start_cyc = 0, done_cnt = 0, done_cyc = 0, err_cyc = 0;
    logic        prev_err = 1'b0;
    logic        have_prev = 1'b0;
    logic [5:0]  prev_addr = 6'd0;
    logic [31:0] prev_data = 32'd0;

    // Responder / PLL controls set by the main sequence
    int stall_addr = -1, stall_len = 0;
    bit rand_wait = 1'b0, pll_auto = 1'b1, pll_level = 1'b1;
    int drop_dly = -1, rise_dly = 0;
    // Responder / PLL private state
    int stall_used = 0, last_start = 0, pll_phase = 0, pll_cnt = 0, rise_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Responder waitrequest and PLL lock behaviour, updated just after each edge
    always @(posedge clk) begin
        #1;
        if (!m_busy) stall_used = 0;
        if (m_write && (int'(m_addr) == stall_addr) && (stall_used < stall_len)) begin
            waitreq = 1'b1;
            stall_used++;
        end else if (rand_wait) begin
            waitreq = ($urandom_range(0, 3) == 0);
        end else begin
            waitreq = 1'b0;
        end
        if (!pll_auto) begin
            pll_locked = pll_level;
            pll_phase  = 0;
            last_start = start_cnt;
        end else begin
            if (start_cnt != last_start) begin
                last_start = start_cnt;
                if (drop_dly >= 0) begin
                    pll_phase = 1;
                    pll_cnt   = drop_dly;
                end
            end
            if (pll_phase == 1) begin
                if (pll_cnt == 0) begin
                    pll_locked = 1'b0;
                    pll_phase  = 2;
                    pll_cnt    = rise_dly;
                end else pll_cnt--;
            end else if (pll_phase == 2) begin
                if (pll_cnt == 0) begin
                    pll_locked = 1'b1;
                    pll_phase  = 0;
                    rise_cyc   = cyc;
                end else pll_cnt--;
            end
        end
    end

    // Bus monitor: records completed writes and checks stalled writes hold still
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            obs_a.delete();
            obs_d.delete();
            obs_cyc.delete();
            have_prev = 1'b0;
            prev_err  = 1'b0;
        end else begin
            if (have_prev) begin
                checks++;
                assert (m_write === 1'b1 && m_addr === prev_addr && m_data === prev_data) else begin
                    errors++;
                    $error("FAIL stall_hold: observed wr=%b a=%0d d=%h expected wr=1 a=%0d d=%h",
                           m_write, m_addr, m_data, prev_addr, prev_data);
                end
            end
            have_prev = 1'b0;
            if (m_write === 1'b1) begin
                if (waitreq) begin
                    have_prev = 1'b1;
                    prev_addr = m_addr;
                    prev_data = m_data;
                end else begin
                    obs_a.push_back(m_addr);
                    obs_d.push_back(m_data);
                    obs_cyc.push_back(cyc);
                    if (m_addr == 6'd2) begin
                        start_cnt++;
                        start_cyc = cyc;
                    end
                end
            end
            if (m_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                checks++;
                assert (m_busy === 1'b0) else begin
                    errors++;
                    $error("FAIL busy_at_done: observed %b expected 0", m_busy);
                end
            end
            if (m_error === 1'b1 && !prev_err) err_cyc = cyc;
            prev_err = m_error;
        end
    end

    // One full request on instance s; the expected write list comes from the register map
    task automatic run_txn(input int s, input logic [17:0] n, input logic [17:0] m,
                           input logic [31:0] k, input logic [22:0] c,
                           input bit exp_err, input string tag, output int base_o);
        logic [5:0]  ea[$];
        logic [31:0] ed[$];
        int base, d0, i;
        sel = s;
        ea.push_back(6'd0); ed.push_back(32'd0);
        ea.push_back(6'd3); ed.push_back({14'd0, n});
        ea.push_back(6'd4); ed.push_back({14'd0, m});
        if (s == 0) begin ea.push_back(6'd7); ed.push_back(k); end
        ea.push_back(6'd5); ed.push_back({9'd0, c});
        ea.push_back(6'd2); ed.push_back(32'd1);
        base   = obs_a.size();
        base_o = base;
        d0     = done_cnt;
        req_n = n; req_m = m; req_k = k; req_c = c;
        if (s == 0) a_valid = 1'b1; else b_valid = 1'b1;
        step();
        chk({tag, "_busy_after_accept"}, 64'(m_busy), 64'd1);
        chk({tag, "_ready_while_busy"}, 64'(m_ready), 64'd0);
        chk({tag, "_error_cleared"}, 64'(m_error), 64'd0);
        // Requests presented while busy must be ignored.
        for (int j = 0; j < 3; j++) begin
            req_n = 18'($urandom); req_m = 18'($urandom);
            req_k = $urandom;      req_c = 23'($urandom);
            step();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        i = 0;
        while (m_busy === 1'b1 && i < 2000) begin
            step();
            i++;
        end
        chk({tag, "_finish_bound"}, 64'(i < 2000), 64'd1);
        chk({tag, "_done_at_exit"}, 64'(m_done), 64'(!exp_err));
        chk({tag, "_error_at_exit"}, 64'(m_error), 64'(exp_err));
        step();
        chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'(!exp_err));
        chk({tag, "_write_count"}, 64'(obs_a.size() - base), 64'(ea.size()));
        for (int j = 0; j < ea.size(); j++) begin
            if (base + j < obs_a.size()) begin
                chk($sformatf("%s_addr%0d", tag, j), 64'(obs_a[base + j]), 64'(ea[j]));
                chk($sformatf("%s_data%0d", tag, j), 64'(obs_d[base + j]), 64'(ed[j]));
            end
        end
    endtask

    int b0;

    // Directed and randomized sequence
    initial begin
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        req_n = 18'd0; req_m = 18'd0; req_k = 32'd0; req_c = 23'd0;
        step(); step(); step();
        rst_n = 1'b1;
        step(); step();

        // Reset state of both instances
        chk("rst_ready_a", 64'(a_ready), 64'd1);
        chk("rst_busy_a",  64'(a_busy),  64'd0);
        chk("rst_write_a", 64'(a_write), 64'd0);
        chk("rst_done_a",  64'(a_done),  64'd0);
        chk("rst_error_a", 64'(a_error), 64'd0);
        chk("rst_ready_b", 64'(b_ready), 64'd1);
        chk("rst_write_b", 64'(b_write), 64'd0);

        // Nominal retune: six back-to-back writes, lock drops 3 cycles after START, rises 50 later
        drop_dly = 3; rise_dly = 49;
        run_txn(0, 18'h00202, 18'h00808, 32'h80000000, 23'h040303, 1'b0, "nominal", b0);
        for (int j = 1; j < 6; j++)
            if (b0 + j < obs_cyc.size())
                chk($sformatf("nominal_consecutive%0d", j), 64'(obs_cyc[b0 + j] - obs_cyc[b0]), 64'(j));
        // Two synchronizer flops plus the state register between lock rising and done.
        chk("nominal_relock_latency", 64'(done_cyc - rise_cyc), 64'd4);

        // Four stall cycles on the M write: held for five cycles before N+1 proceeds
        stall_addr = 4; stall_len = 4; drop_dly = 2; rise_dly = 10;
        run_txn(0, 18'h00123, 18'h00808, 32'h12345678, 23'h0a0101, 1'b0, "stall_m", b0);
        if (b0 + 3 < obs_cyc.size())
            chk("stall_m_cycles", 64'(obs_cyc[b0 + 2] - obs_cyc[b0 + 1]), 64'd5);
        stall_addr = -1; stall_len = 0;

        // No fractional write when FRAC_EN=0
        run_txn(1, 18'($urandom), 18'($urandom), $urandom, 23'($urandom), 1'b0, "nofrac", b0);

        // Lock never returns: error after LOCK_TIMEOUT cycles in WAIT_LOCK
        pll_auto = 1'b0; pll_level = 1'b0;
        step(); step(); step(); step();
        run_txn(0, 18'h00011, 18'h00022, 32'h0, 23'h000033, 1'b1, "timeout", b0);
        // One WAIT_UNLOCK cycle (lock already low), LT cycles of WAIT_LOCK, then ERR.
        chk("timeout_latency", 64'(err_cyc - start_cyc), 64'(LT + 2));
        step(); step(); step();
        chk("timeout_sticky", 64'(a_error), 64'd1);
        pll_level = 1'b1;
        step(); step(); step(); step();
        pll_auto = 1'b1; drop_dly = -1;
        // Lock never drops: WAIT_UNLOCK expires after UNLOCK_WAIT cycles, then immediate done
        run_txn(0, 18'h00044, 18'h00055, 32'h66, 23'h000077, 1'b0, "clear_err", b0);
        chk("no_drop_latency", 64'(done_cyc - start_cyc), 64'(UW + 2));

        // Reset asserted while the C write is stalled
        sel = 0; stall_addr = 5; stall_len = 100000;
        req_n = 18'h1; req_m = 18'h2; req_k = 32'h3; req_c = 23'h4;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        for (int j = 0; j < 50 && !(a_write && a_addr == 6'd5); j++) step();
        chk("midreset_reached_wc", 64'(a_write && a_addr == 6'd5), 64'd1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_write", 64'(a_write), 64'd0);
        chk("midreset_busy",  64'(a_busy),  64'd0);
        chk("midreset_ready", 64'(a_ready), 64'd1);
        step(); step();
        rst_n = 1'b1;
        stall_addr = -1; stall_len = 0;
        step(); step(); step();
        drop_dly = 1; rise_dly = 5;
        run_txn(0, 18'h3ffff, 18'h00001, 32'hdeadbeef, 23'h7fffff, 1'b0, "after_reset", b0);

        // Randomized requests with random stalls and random lock behaviour
        rand_wait = 1'b1;
        for (int t = 0; t < 8; t++) begin
            drop_dly = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 6));
            rise_dly = int'($urandom_range(0, 30));
            run_txn((t % 4 == 3) ? 1 : 0, 18'($urandom), 18'($urandom), $urandom, 23'($urandom),
                    1'b0, $sformatf("rand%0d", t), b0);
            if (drop_dly < 0) chk($sformatf("rand%0d_nodrop_latency", t), 64'(done_cyc - start_cyc), 64'(UW + 2));
            else              chk($sformatf("rand%0d_relock_latency", t), 64'(done_cyc - rise_cyc), 64'd4);
        end
        rand_wait = 1'b0;
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
